// File: rtl/quant_layer_sequencer_if.sv
// quant_layer_sequencer_if: host control, quant LUT and compute-engine signals of the layer sequencer
interface quant_layer_sequencer_if #(parameter int IDX_W = 5);
  logic start, abort, layer_done, layer_start, busy, done, aborted, q_bypass;
  logic [IDX_W-1:0] lut_layer_sel, layer_idx;
  logic [31:0] lut_mult, q_mult;
  logic [5:0] lut_shift, q_shift;
  logic [7:0] lut_zp, q_zp;
  modport slave (
    input start, abort, layer_done, lut_mult, lut_shift, lut_zp,
    output lut_layer_sel, layer_idx, q_mult, q_shift, q_zp, q_bypass, layer_start, busy, done, aborted
  );
  modport master (
    output start, abort, layer_done, lut_mult, lut_shift, lut_zp,
    input lut_layer_sel, layer_idx, q_mult, q_shift, q_zp, q_bypass, layer_start, busy, done, aborted
  );
endinterface

// File: rtl/quant_layer_sequencer.sv
// quant_layer_sequencer: walks the network layers, latches quant params from the LUT and handshakes each layer with the engine
module quant_layer_sequencer #(
  parameter int NUM_LAYERS = 29,
  parameter int AP_LAYER = 27,
  parameter int IDX_W = 5
) (
  input logic clk,
  input logic rst,
  quant_layer_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RUN, FINISH} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LAYERS - 1);
  localparam logic [IDX_W-1:0] AP = IDX_W'(AP_LAYER);
  state_t r_state;
  logic [IDX_W-1:0] r_idx;
  logic [31:0] r_mult;
  logic [5:0] r_shift;
  logic [7:0] r_zp;
  logic r_bypass, r_start, r_done, r_aborted;
  assign bus.lut_layer_sel = r_idx;
  assign bus.layer_idx = r_idx;
  assign bus.q_mult = r_mult;
  assign bus.q_shift = r_shift;
  assign bus.q_zp = r_zp;
  assign bus.q_bypass = r_bypass;
  assign bus.layer_start = r_start;
  assign bus.done = r_done;
  assign bus.aborted = r_aborted;
  assign bus.busy = r_state != IDLE;
  // sequencer FSM; pulses are registered so each is high exactly in the state it belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_mult <= '0;
      r_shift <= '0;
      r_zp <= '0;
      r_bypass <= 1'b0;
      r_start <= 1'b0;
      r_done <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done <= 1'b0;
      r_aborted <= 1'b0;
      if (r_state != IDLE && bus.abort) begin
        r_state <= IDLE;
        r_idx <= '0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          IDLE: if (bus.start) begin
            r_idx <= '0;
            r_state <= LOAD;
          end
          LOAD: begin
            r_mult <= bus.lut_mult;
            r_shift <= bus.lut_shift;
            r_zp <= bus.lut_zp;
            r_bypass <= r_idx == AP;
            r_start <= 1'b1;
            r_state <= ISSUE;
          end
          ISSUE: r_state <= RUN;
          RUN: if (bus.layer_done) begin
            r_state <= r_idx == LAST ? FINISH : LOAD;
            r_idx <= r_idx == LAST ? r_idx : r_idx + 1'b1;
            r_done <= r_idx == LAST;
          end
          FINISH: begin
            r_idx <= '0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_quant_layer_sequencer.sv
// tb_quant_layer_sequencer: directed checks of layer sequencing, quant capture, abort and async reset
module tb_quant_layer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0, bad = 0, n_ls = 0, n_done = 0, n_ab = 0;
  int b_ls, b_d, b_ab;
  always #5 clk = ~clk;
  quant_layer_sequencer_if #(.IDX_W(5)) bus();
  quant_layer_sequencer #(.NUM_LAYERS(29), .AP_LAYER(27), .IDX_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [31:0] f_mult(int s);
    return s == 0 ? 32'd1499917960 : s == 27 ? 32'd1 : s == 28 ? 32'd1370706446 : 32'h1000_0000 + 32'(s * 1234567);
  endfunction
  function automatic logic [5:0] f_shift(int s);
    return s == 0 ? 6'd36 : s == 27 ? 6'd0 : s == 28 ? 6'd38 : 6'(s + 8);
  endfunction
  function automatic logic [7:0] f_zp(int s);
    return s == 0 ? 8'(-105) : s == 27 ? 8'd0 : s == 28 ? 8'd74 : 8'(s * 3 + 1);
  endfunction
  always_comb begin
    bus.lut_mult = f_mult(int'(bus.lut_layer_sel));
    bus.lut_shift = f_shift(int'(bus.lut_layer_sel));
    bus.lut_zp = f_zp(int'(bus.lut_layer_sel));
  end
  always @(negedge clk) begin
    if (bus.layer_start === 1'b1) n_ls++;
    if (bus.done === 1'b1) n_done++;
    if (bus.aborted === 1'b1) n_ab++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_ls(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.layer_start !== 1'b1 && waited < 20);
  endtask
  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("load_busy", bus.busy, 1);
    chk("load_no_ls", bus.layer_start, 0);
  endtask
  task automatic do_run(input int last, input int ndone);
    int w;
    start_pulse();
    for (int i = 0; i <= last; i++) begin
      wait_ls(w);
      chk("ls_latency", w, 1);
      chk("layer_idx", bus.layer_idx, i);
      chk("lut_sel", bus.lut_layer_sel, i);
      chk("q_mult", bus.q_mult, f_mult(i));
      chk("q_shift", bus.q_shift, f_shift(i));
      chk("q_zp", bus.q_zp, f_zp(i));
      chk("q_bypass", bus.q_bypass, i == 27);
      bus.layer_done = i == 5;
      if (i < ndone) begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          bus.layer_done = 1'b0;
          bus.start = i == 10 && k == 0;
        end
        chk("run_idx_hold", bus.layer_idx, i);
        chk("run_no_ls", bus.layer_start, 0);
        bus.layer_done = 1'b1;
        @(negedge clk);
        bus.layer_done = 1'b0;
        if (i == 28) begin
          chk("fin_done", bus.done, 1);
          chk("fin_busy", bus.busy, 1);
          chk("fin_idx", bus.layer_idx, 28);
          @(negedge clk);
          chk("idle_done", bus.done, 0);
          chk("idle_busy", bus.busy, 0);
          chk("idle_idx", bus.layer_idx, 0);
          chk("idle_q_mult_held", bus.q_mult, f_mult(28));
          chk("idle_q_zp_held", bus.q_zp, f_zp(28));
        end else begin
          chk("load_q_held", bus.q_mult, f_mult(i));
          chk("load_ls", bus.layer_start, 0);
          chk("load_busy2", bus.busy, 1);
        end
      end
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.layer_done = 1'b0;
    #2 rst = 1'b1;
    #10;
    chk("rst_idx", bus.layer_idx, 0);
    chk("rst_sel", bus.lut_layer_sel, 0);
    chk("rst_q", {bus.q_mult, bus.q_shift, bus.q_zp, bus.q_bypass}, 0);
    chk("rst_pulses", {bus.layer_start, bus.busy, bus.done, bus.aborted}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ignored", {bus.busy, bus.aborted}, 0);
    b_ls = n_ls;
    b_d = n_done;
    do_run(28, 29);
    chk("run1_ls_count", n_ls - b_ls, 29);
    chk("run1_done_count", n_done - b_d, 1);
    bus.layer_done = 1'b1;
    @(negedge clk);
    bus.layer_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("spurious_busy", bus.busy, 0);
    chk("spurious_idx", bus.layer_idx, 0);
    chk("spurious_ls", n_ls - b_ls, 29);
    b_ab = n_ab;
    b_d = n_done;
    do_run(12, 12);
    @(negedge clk);
    bus.abort = 1'b1;
    bus.layer_done = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.layer_done = 1'b0;
    chk("abort_pulse", bus.aborted, 1);
    chk("abort_no_done", bus.done, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_idx", bus.layer_idx, 0);
    @(negedge clk);
    chk("abort_one_cycle", bus.aborted, 0);
    chk("abort_count", n_ab - b_ab, 1);
    chk("abort_done_count", n_done - b_d, 0);
    b_ab = n_ab;
    do_run(20, 20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_q", {bus.q_mult, bus.q_shift, bus.q_zp, bus.q_bypass}, 0);
    chk("arst_ctl", {bus.layer_start, bus.busy, bus.done, bus.aborted}, 0);
    chk("arst_idx", bus.layer_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_no_done", n_done - b_d, 0);
    chk("arst_no_abort", n_ab - b_ab, 0);
    b_ls = n_ls;
    b_d = n_done;
    do_run(28, 29);
    chk("run2_ls_count", n_ls - b_ls, 29);
    chk("run2_done_count", n_done - b_d, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
